// File: rtl/div_seq.sv
// Sequential N-bit restoring divider with start/busy/done handshake, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX state for sign correction).
module div_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0]  r, r_d;
  logic [N-1:0]  q, q_d;
  logic [N-1:0]  dvd, dvd_d;
  logic [N-1:0]  dvs, dvs_d;
  logic          busy_d, done_d, dz_d;
  logic [N-1:0]  quo_d, rem_d;
  logic [N:0]    trial;
`ifdef DIV_SIGNED_EN
  logic          neg_q, neg_q_d;
  logic          neg_r, neg_r_d;
`endif

  // State, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      dvd       <= '0;
      dvs       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      r         <= r_d;
      q         <= q_d;
      dvd       <= dvd_d;
      dvs       <= dvs_d;
      busy      <= busy_d;
      done      <= done_d;
      quotient  <= quo_d;
      remainder <= rem_d;
      div_zero  <= dz_d;
`ifdef DIV_SIGNED_EN
      neg_q     <= neg_q_d;
      neg_r     <= neg_r_d;
`endif
    end
  end

  // Trial subtraction; the shifted remainder keeps its carried-out bit as bit N.
  assign trial = {r, dvd[N-1]} - {1'b0, dvs};

  // Next-state and next-register logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    r_d     = r;
    q_d     = q;
    dvd_d   = dvd;
    dvs_d   = dvs;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quo_d   = quotient;
    rem_d   = remainder;
    dz_d    = div_zero;
`ifdef DIV_SIGNED_EN
    neg_q_d = neg_q;
    neg_r_d = neg_r;
`endif
    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_d = IDLE;
        if (start) begin
          if (b == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            rem_d   = a;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            cnt_d   = '0;
            r_d     = '0;
            q_d     = '0;
            dz_d    = 1'b0;
`ifdef DIV_SIGNED_EN
            dvd_d   = a[N-1] ? (~a + N'(1)) : a;
            dvs_d   = b[N-1] ? (~b + N'(1)) : b;
            neg_q_d = a[N-1] ^ b[N-1];
            neg_r_d = a[N-1];
`else
            dvd_d   = a;
            dvs_d   = b;
`endif
          end
        end
      end
      RUN: begin
        dvd_d = {dvd[N-2:0], 1'b0};
        cnt_d = cnt + CW'(1);
        if (!trial[N]) begin
          r_d = trial[N-1:0];
          q_d = {q[N-2:0], 1'b1};
        end else begin
          r_d = {r[N-2:0], dvd[N-1]};
          q_d = {q[N-2:0], 1'b0};
        end
        if (cnt == LAST) begin
`ifdef DIV_SIGNED_EN
          state_d = FIX;
          busy_d  = 1'b1;
`else
          state_d = DONE;
          done_d  = 1'b1;
          quo_d   = q_d;
          rem_d   = r_d;
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
`ifdef DIV_SIGNED_EN
      FIX: begin
        state_d = DONE;
        done_d  = 1'b1;
        quo_d   = neg_q ? (~q + N'(1)) : q;
        rem_d   = neg_r ? (~r + N'(1)) : r;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; expected values are hand-computed constants.
// Latency expectations follow DIV_SIGNED_EN when the bench is built with it.
module tb_div_seq;

  localparam int unsigned N = 32;
`ifdef DIV_SIGNED_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] a, b;
  logic         busy, done, div_zero;
  logic [N-1:0] quotient, remainder;

  int checks   = 0;
  int failures = 0;

  div_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and samples both sit 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done (cycle counter starts at 1 right after acceptance), counting busy cycles.
  task automatic wait_done(input string tag, inout int cyc, output int nbusy);
    int overlap = 0;
    nbusy = 0;
    while (!done && cyc < 300) begin
      if (busy) nbusy++;
      tick();
      cyc++;
      if (busy && done) overlap++;
    end
    check({tag, "_timeout"}, 64'(done), 64'(1));
    check({tag, "_overlap"}, 64'(overlap), 64'(0));
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz,
                         input int elat, input int ebusy);
    int cyc, nbusy;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0;
    cyc = 1;
    wait_done(tag, cyc, nbusy);
    check({tag, "_lat"}, 64'(cyc), 64'(elat));
    check({tag, "_busycyc"}, 64'(nbusy), 64'(ebusy));
    check({tag, "_q"}, 64'(quotient), 64'(eq));
    check({tag, "_r"}, 64'(remainder), 64'(er));
    check({tag, "_dz"}, 64'(div_zero), 64'(edz));
    tick();
    check({tag, "_pulse"}, 64'(done), 64'(0));
    check({tag, "_hold_q"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    int cyc, nbusy, seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_q", 64'(quotient), 64'(0));
    check("rst_r", 64'(remainder), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, LAT - 1);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT, LAT - 1);
    run_div("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, LAT, LAT - 1);
    run_div("d1000_10", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, LAT, LAT - 1);
    run_div("dzero", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 0);
    run_div("after_dz", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, LAT, LAT - 1);
`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT, LAT - 1);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT, LAT - 1);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT, LAT - 1);
`else
    run_div("u_bigdiv", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, LAT, LAT - 1);
    run_div("u_big_a", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, LAT, LAT - 1);
`endif

    // start during cycle 10 of a divide is ignored
    a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1;
    while (cyc < 10) begin tick(); cyc++; end
    a = 32'd9; b = 32'd3; start = 1'b1;
    tick(); cyc++;
    start = 1'b0;
    wait_done("ign", cyc, nbusy);
    check("ign_lat", 64'(cyc), 64'(LAT));
    check("ign_q", 64'(quotient), 64'(14));
    check("ign_r", 64'(remainder), 64'(2));

    // start held high through DONE: a second divide is accepted from DONE
    tick();
    a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    cyc = 1;
    wait_done("held1", cyc, nbusy);
    check("held1_lat", 64'(cyc), 64'(LAT));
    check("held1_q", 64'(quotient), 64'(14));
    a = 32'd5; b = 32'd9;
    tick();
    start = 1'b0;
    cyc = 1;
    check("held2_busy", 64'(busy), 64'(1));
    wait_done("held2", cyc, nbusy);
    check("held2_lat", 64'(cyc), 64'(LAT));
    check("held2_q", 64'(quotient), 64'(0));
    check("held2_r", 64'(remainder), 64'(5));
    tick();

    // reset in cycle 15 aborts the divide without a done pulse
    a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1;
    while (cyc < 15) begin tick(); cyc++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_q", 64'(quotient), 64'(0));
    check("arst_r", 64'(remainder), 64'(0));
    check("arst_dz", 64'(div_zero), 64'(0));
    seen = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      if (done || busy) seen++;
      tick();
    end
    check("arst_quiet", 64'(seen), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
